cache_refill_ctrl: RTL and testbench
====================================

// Module: cache_refill_ctrl
// PURPOSE
//  Miss/write sequencer between the 16-set, 2-way, 4-word-block data cache and main memory.
//  - Read miss: stalls the CPU and burst-refills the whole block, one word per mem_ack.
//  - Write (hit or miss): performs the write-through transaction to memory.
//  - Sits beside the cache. Drives the cache fill port and the single req/ack memory port.
// PARAMETERS
//  BLOCK_WORDS  4   words per cache block; power of two, >=2
//  OFFSET_W     2   $clog2(BLOCK_WORDS); width of word-in-block offset
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  cpu_req    in   1   CPU memory access valid this cycle
//  cpu_we     in   1   access is a store
//  cpu_addr   in   30  word address [31:2]
//  cpu_wdata  in   32  store data
//  cache_hit  in   1   cache lookup hit for cpu_addr (combinational from cache)
//  stall      out  1   freeze CPU memory stage
//  fill_en    out  1   write fill_data into the cache line at fill_addr this cycle
//  fill_addr  out  30  word address being filled
//  fill_data  out  32  refill word (registered mem_rdata path not required; pass-through)
//  mem_req    out  1   memory request valid
//  mem_we     out  1   memory request is a write
//  mem_addr   out  30  memory word address
//  mem_wdata  out  32  memory write data
//  mem_ack    in   1   memory completes current request this cycle; mem_rdata valid when !mem_we
//  mem_rdata  in   32  memory read data
// BEHAVIOUR
//  Reset (async, rst=1):
//  - state=IDLE; cnt=0; latched addr/data=0.
//  - Outputs: stall, fill_en, mem_req, mem_we=0. fill_addr, mem_addr, mem_wdata=0.
//  FSM states IDLE, REFILL, WRITE, DONE. Transitions:
//  IDLE:
//  - cpu_req & cpu_we -> latch addr/wdata -> WRITE. stall=1 combinationally this cycle.
//  - cpu_req & !cpu_we & !cache_hit -> base={cpu_addr[29:OFFSET_W],0}; cnt=0 -> REFILL. stall=1 combinationally.
//  - Otherwise: stall=0 (hit completes with zero added latency).
//  REFILL:
//  - Outputs: mem_req=1, mem_we=0, mem_addr=base|cnt, stall=1.
//  - On mem_ack: fill_en=1 same cycle, fill_addr=mem_addr, fill_data=mem_rdata, cnt++.
//  - mem_ack with cnt==BLOCK_WORDS-1 -> DONE. Offset increments inside block only; never carries into set/tag.
//  WRITE:
//  - Outputs: mem_req=1, mem_we=1, mem_addr/mem_wdata=latched values, stall=1.
//  - mem_ack -> DONE.
//  DONE:
//  - stall=0, mem_req=0; CPU retries lookup, now hits.
//  - Next state IDLE unconditionally; a new request is evaluated only from IDLE.
//  Handshake:
//  - mem_req, mem_addr, mem_we and mem_wdata are held stable until the mem_ack cycle.
//  - mem_ack while mem_req=0 is ignored.
//  - Zero-wait memory (ack same cycle as req) allowed: a refill takes BLOCK_WORDS cycles.
//  Latency: read miss = 1 (IDLE) + BLOCK_WORDS acks + 1 (DONE); write = 1 + 1 ack + 1.
//  Boundaries:
//  - cpu_req dropped or cpu_addr changed during stall: ignored; transaction completes on latched values.
//  - rst mid-REFILL/WRITE: immediate IDLE, outstanding mem request abandoned. The cache is reset by the
//    same rst, so no partial line survives.
//  - fill_en never asserted outside REFILL.
// STRUCTURE
//  - Shared package cache_pkg: refill_state_e enum; BLOCK_WORDS, OFFSET_W, NUM_SETS, NUM_WAYS, TAG_W
//    constants (used also by the cache).
//  - Single module: one state register, one OFFSET_W counter, address/data latches.
//  - No sub-module is natural.
// TESTING
//  1. rst high mid-REFILL (cnt=2) -> next sampled: stall=0, mem_req=0, fill_en=0, state IDLE.
//  2. Read miss addr 0x0000_0124 (word 0x49), ack every cycle
//     -> mem_addr 0x48,0x49,0x4A,0x4B; fill_en 4 cycles; stall 5 cycles then 0.
//  3. Read miss, memory acks after 3 wait cycles per word -> mem_req/mem_addr stable while waiting;
//     exactly 4 fill_en pulses.
//  4. Store 0xDEADBEEF to word 0x10, hit -> one mem_we=1 req with mem_addr 0x10, mem_wdata 0xDEADBEEF;
//     stall until DONE.
//  5. Read hit in IDLE -> stall=0, mem_req=0 same cycle.
//  6. Spurious mem_ack in IDLE; cpu_req dropped mid-refill -> no fill_en in IDLE; refill still completes 4 words.

Source files
------------

// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
//   Shared constants and types for the 16-set, 2-way, 4-word-block data cache
//   and its miss/write sequencer (cache_refill_ctrl).
//
//   Address split (word address, 30 bits):
//     [29 : INDEX_W+OFFSET_W]       tag    (TAG_W bits)
//     [INDEX_W+OFFSET_W-1:OFFSET_W] set index
//     [OFFSET_W-1:0]                word-in-block offset
// ---------------------------------------------------------------------------
package cache_pkg;

  localparam int WORD_ADDR_W = 30;
  localparam int DATA_W      = 32;

  localparam int BLOCK_WORDS = 4;
  localparam int OFFSET_W    = $clog2(BLOCK_WORDS);
  localparam int NUM_SETS    = 16;
  localparam int NUM_WAYS    = 2;
  localparam int INDEX_W     = $clog2(NUM_SETS);
  localparam int TAG_W       = WORD_ADDR_W - INDEX_W - OFFSET_W;

  // Sequencer states. IDLE is the only state that looks at a new CPU request.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } refill_state_e;

endpackage

// File: rtl/cache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// cache_refill_ctrl
//   Miss/write sequencer sitting beside the data cache.
//   - Read miss : stalls the CPU and burst-refills the whole block from memory,
//                 one word per mem_ack, writing each word into the cache via the
//                 fill port in the same cycle it is acknowledged.
//   - Store     : performs one write-through transaction (hit or miss).
//   - Read hit  : passes straight through, no stall.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   cpu_req/we/addr/wdata    CPU access request (word address)
//   cache_hit                combinational lookup result for cpu_addr
//   stall                    freeze the CPU memory stage
//   fill_en/addr/data        cache line fill port
//   mem_req/we/addr/wdata    single memory request port
//   mem_ack, mem_rdata       memory completion and read data
//   dbg_state                current sequencer state (refill_state_e encoding)
//
// Memory handshake: mem_req/mem_we/mem_addr/mem_wdata come straight from
// registers and are held stable from the first request cycle through the
// mem_ack cycle; the request completes in the cycle where mem_req and mem_ack
// are both high. mem_ack while mem_req is low is ignored. An ack in the very
// first request cycle (zero-wait memory) is allowed.
// ---------------------------------------------------------------------------
module cache_refill_ctrl #(
  parameter int BLOCK_WORDS = cache_pkg::BLOCK_WORDS,
  parameter int OFFSET_W    = cache_pkg::OFFSET_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [29:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cache_hit,
  output logic        stall,
  output logic        fill_en,
  output logic [29:0] fill_addr,
  output logic [31:0] fill_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  import cache_pkg::*;

  localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(BLOCK_WORDS - 1);

  refill_state_e        state_q, state_d;
  logic [OFFSET_W-1:0]  cnt_q,   cnt_d;
  // addr_q always holds the address currently presented on the memory port:
  // the store address in WRITE, base|cnt in REFILL.
  logic [29:0]          addr_q,  addr_d;
  logic [31:0]          wdata_q, wdata_d;

  logic in_idle, in_refill, in_write;
  logic new_write, new_miss;

  assign in_idle   = (state_q == ST_IDLE);
  assign in_refill = (state_q == ST_REFILL);
  assign in_write  = (state_q == ST_WRITE);

  // New work is only accepted from IDLE; DONE deliberately ignores cpu_req so
  // the CPU's retried lookup is seen fresh one cycle later.
  assign new_write = in_idle && cpu_req && cpu_we;
  assign new_miss  = in_idle && cpu_req && !cpu_we && !cache_hit;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (new_write) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = ST_WRITE;
        end else if (new_miss) begin
          // Refill always starts at word 0 of the block, not at the missing word.
          addr_d  = {cpu_addr[29:OFFSET_W], {OFFSET_W{1'b0}}};
          cnt_d   = '0;
          state_d = ST_REFILL;
        end
      end

      ST_REFILL: begin
        if (mem_ack) begin
          cnt_d = cnt_q + OFFSET_W'(1);
          // Only the offset field advances, so the burst can never carry into
          // the set index or tag even at the top of the address space.
          addr_d[OFFSET_W-1:0] = cnt_q + OFFSET_W'(1);
          if (cnt_q == LAST_WORD) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_WRITE: begin
        if (mem_ack) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  // The memory port is a pure function of registered state, so it is stable
  // for the whole request regardless of what the CPU does meanwhile.
  assign mem_req   = in_refill || in_write;
  assign mem_we    = in_write;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Stall must rise in the same IDLE cycle the miss/store is seen, otherwise
  // the CPU would advance past the access.
  assign stall = new_write || new_miss || in_refill || in_write;

  // Fill is gated by REFILL so a spurious ack elsewhere never touches the cache.
  assign fill_en   = in_refill && mem_ack;
  assign fill_addr = addr_q;
  assign fill_data = mem_rdata;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_refill_ctrl
//   Directed self-checking bench for cache_refill_ctrl. Inputs are driven 1ns
//   after the rising edge; outputs are sampled 4ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_cache_refill_ctrl;
  import cache_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cache_hit;
  logic [29:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        stall, fill_en, mem_req, mem_we, mem_ack;
  logic [29:0] fill_addr, mem_addr;
  logic [31:0] fill_data, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_refill_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cache_hit (cache_hit),
    .stall     (stall),
    .fill_en   (fill_en),
    .fill_addr (fill_addr),
    .fill_data (fill_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic drive_idle();
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cache_hit = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    tick();
    tick();
    settle();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", stall); end
    checks++; if (fill_en !== 1'b0) begin errors++; $display("FAIL reset_fill_en got %0b exp 0", fill_en); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %0b exp 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %0b exp 0", mem_we); end
    checks++; if (mem_addr !== 30'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
    checks++; if (fill_addr !== 30'h0) begin errors++; $display("FAIL reset_fill_addr got %h exp 0", fill_addr); end
    checks++; if (dbg_state !== 2'(ST_IDLE)) begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, ST_IDLE); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_rst_mid_refill();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 30'h201; cache_hit = 1'b0;
    settle();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rstmid_issue_stall got %0b exp 1", stall); end
    tick();
    cpu_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1111_0000;
    tick();
    tick();
    mem_ack = 1'b0;
    settle();
    checks++; if (mem_addr !== 30'h202) begin errors++; $display("FAIL rstmid_cnt2_addr got %h exp 202", mem_addr); end
    checks++; if (dbg_state !== 2'(ST_REFILL)) begin errors++; $display("FAIL rstmid_pre_state got %0d exp %0d", dbg_state, ST_REFILL); end
    rst = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall got %0b exp 0", stall); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rstmid_mem_req got %0b exp 0", mem_req); end
    checks++; if (fill_en !== 1'b0) begin errors++; $display("FAIL rstmid_fill_en got %0b exp 0", fill_en); end
    checks++; if (dbg_state !== 2'(ST_IDLE)) begin errors++; $display("FAIL rstmid_state got %0d exp %0d", dbg_state, ST_IDLE); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_miss_zero_wait();
    int stall_cycles;
    stall_cycles = 0;
    // Byte address 0x124 -> word 0x49, block base 0x48.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 30'h49; cache_hit = 1'b0;
    settle();
    if (stall === 1'b1) stall_cycles++;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL zw_idle_stall got %0b exp 1", stall); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL zw_idle_mem_req got %0b exp 0", mem_req); end
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_ack = 1'b1;
      mem_rdata = 32'hA5A5_0000 + 32'(i);
      settle();
      if (stall === 1'b1) stall_cycles++;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL zw_req[%0d] got req=%0b we=%0b exp req=1 we=0", i, mem_req, mem_we); end
      checks++; if (mem_addr !== 30'h48 + 30'(i)) begin errors++; $display("FAIL zw_mem_addr[%0d] got %h exp %h", i, mem_addr, 30'h48 + 30'(i)); end
      checks++; if (fill_en !== 1'b1) begin errors++; $display("FAIL zw_fill_en[%0d] got %0b exp 1", i, fill_en); end
      checks++; if (fill_addr !== 30'h48 + 30'(i)) begin errors++; $display("FAIL zw_fill_addr[%0d] got %h exp %h", i, fill_addr, 30'h48 + 30'(i)); end
      checks++; if (fill_data !== 32'hA5A5_0000 + 32'(i)) begin errors++; $display("FAIL zw_fill_data[%0d] got %h exp %h", i, fill_data, 32'hA5A5_0000 + 32'(i)); end
      tick();
    end
    mem_ack = 1'b0;
    cache_hit = 1'b1;
    settle();
    if (stall === 1'b1) stall_cycles++;
    checks++; if (dbg_state !== 2'(ST_DONE)) begin errors++; $display("FAIL zw_done_state got %0d exp %0d", dbg_state, ST_DONE); end
    checks++; if (stall !== 1'b0 || mem_req !== 1'b0 || fill_en !== 1'b0) begin errors++; $display("FAIL zw_done_outs got stall=%0b req=%0b fill=%0b exp 0 0 0", stall, mem_req, fill_en); end
    checks++; if (stall_cycles != 5) begin errors++; $display("FAIL zw_stall_cycles got %0d exp 5", stall_cycles); end
    tick();
    settle();
    checks++; if (dbg_state !== 2'(ST_IDLE) || stall !== 1'b0) begin errors++; $display("FAIL zw_retry_hit got state=%0d stall=%0b exp 0 0", dbg_state, stall); end
    drive_idle();
    tick();
  endtask

  task automatic test_read_miss_wait();
    int fills;
    fills = 0;
    // Top of the address space: offset must wrap inside the block only.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 30'h3FFF_FFFE; cache_hit = 1'b0;
    tick();
    cpu_req = 1'b0;
    for (int w = 0; w < 4; w++) begin
      for (int k = 0; k < 3; k++) begin
        mem_ack = 1'b0;
        settle();
        if (fill_en === 1'b1) fills++;
        checks++; if (mem_req !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL wt_hold_req[%0d,%0d] got req=%0b stall=%0b exp 1 1", w, k, mem_req, stall); end
        checks++; if (mem_addr !== 30'h3FFF_FFFC + 30'(w)) begin errors++; $display("FAIL wt_hold_addr[%0d,%0d] got %h exp %h", w, k, mem_addr, 30'h3FFF_FFFC + 30'(w)); end
        tick();
      end
      mem_ack = 1'b1;
      mem_rdata = 32'hC0DE_0000 + 32'(w);
      settle();
      if (fill_en === 1'b1) fills++;
      checks++; if (fill_en !== 1'b1 || fill_addr !== 30'h3FFF_FFFC + 30'(w)) begin errors++; $display("FAIL wt_fill[%0d] got en=%0b addr=%h exp 1 %h", w, fill_en, fill_addr, 30'h3FFF_FFFC + 30'(w)); end
      tick();
    end
    mem_ack = 1'b0;
    settle();
    checks++; if (dbg_state !== 2'(ST_DONE)) begin errors++; $display("FAIL wt_done_state got %0d exp %0d", dbg_state, ST_DONE); end
    checks++; if (fills != 4) begin errors++; $display("FAIL wt_fill_count got %0d exp 4", fills); end
    tick();
    drive_idle();
  endtask

  task automatic test_write();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 30'h10; cpu_wdata = 32'hDEAD_BEEF; cache_hit = 1'b1;
    settle();
    checks++; if (stall !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL wr_idle got stall=%0b req=%0b exp 1 0", stall, mem_req); end
    tick();
    // CPU changes its mind while stalled; the latched store must still go out.
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 30'h3333; cpu_wdata = 32'h0;
    settle();
    checks++; if (dbg_state !== 2'(ST_WRITE)) begin errors++; $display("FAIL wr_state got %0d exp %0d", dbg_state, ST_WRITE); end
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL wr_ctrl got req=%0b we=%0b stall=%0b exp 1 1 1", mem_req, mem_we, stall); end
    checks++; if (mem_addr !== 30'h10 || mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_payload got %h/%h exp 10/deadbeef", mem_addr, mem_wdata); end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    settle();
    checks++; if (mem_addr !== 30'h10 || mem_wdata !== 32'hDEAD_BEEF || mem_we !== 1'b1) begin errors++; $display("FAIL wr_ack_payload got %h/%h we=%0b exp 10/deadbeef 1", mem_addr, mem_wdata, mem_we); end
    checks++; if (fill_en !== 1'b0) begin errors++; $display("FAIL wr_no_fill got %0b exp 0", fill_en); end
    tick();
    mem_ack = 1'b0;
    settle();
    checks++; if (dbg_state !== 2'(ST_DONE) || stall !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL wr_done got state=%0d stall=%0b req=%0b exp 3 0 0", dbg_state, stall, mem_req); end
    tick();
    drive_idle();
  endtask

  task automatic test_read_hit();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 30'h77; cache_hit = 1'b1;
    settle();
    checks++; if (stall !== 1'b0 || mem_req !== 1'b0 || fill_en !== 1'b0) begin errors++; $display("FAIL hit_outs got stall=%0b req=%0b fill=%0b exp 0 0 0", stall, mem_req, fill_en); end
    tick();
    settle();
    checks++; if (dbg_state !== 2'(ST_IDLE)) begin errors++; $display("FAIL hit_state got %0d exp %0d", dbg_state, ST_IDLE); end
    tick();
    drive_idle();
  endtask

  task automatic test_spurious_and_drop();
    int fills;
    fills = 0;
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    settle();
    checks++; if (fill_en !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL spur_idle got fill=%0b req=%0b exp 0 0", fill_en, mem_req); end
    tick();
    mem_ack = 1'b0;
    settle();
    checks++; if (dbg_state !== 2'(ST_IDLE)) begin errors++; $display("FAIL spur_state got %0d exp %0d", dbg_state, ST_IDLE); end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 30'h1235; cache_hit = 1'b0;
    tick();
    cpu_req = 1'b0; cpu_addr = 30'h0;
    for (int i = 0; i < 4; i++) begin
      mem_ack = 1'b1; mem_rdata = 32'h5000_0000 + 32'(i);
      settle();
      if (fill_en === 1'b1) fills++;
      checks++; if (mem_addr !== 30'h1234 + 30'(i)) begin errors++; $display("FAIL drop_addr[%0d] got %h exp %h", i, mem_addr, 30'h1234 + 30'(i)); end
      tick();
    end
    mem_ack = 1'b0;
    settle();
    checks++; if (fills != 4 || dbg_state !== 2'(ST_DONE)) begin errors++; $display("FAIL drop_complete got fills=%0d state=%0d exp 4 3", fills, dbg_state); end
    tick();
    drive_idle();
  endtask

  task automatic test_back_to_back();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 30'h20; cpu_wdata = 32'h0000_0001; cache_hit = 1'b0;
    tick();
    mem_ack = 1'b1;
    cpu_addr = 30'h24; cpu_wdata = 32'h0000_0002;
    tick();
    mem_ack = 1'b0;
    settle();
    // DONE must not accept the still-asserted store request.
    checks++; if (dbg_state !== 2'(ST_DONE) || stall !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL b2b_done got state=%0d stall=%0b req=%0b exp 3 0 0", dbg_state, stall, mem_req); end
    tick();
    settle();
    checks++; if (dbg_state !== 2'(ST_IDLE) || stall !== 1'b1) begin errors++; $display("FAIL b2b_idle got state=%0d stall=%0b exp 0 1", dbg_state, stall); end
    tick();
    settle();
    checks++; if (dbg_state !== 2'(ST_WRITE) || mem_addr !== 30'h24 || mem_wdata !== 32'h2) begin errors++; $display("FAIL b2b_second got state=%0d addr=%h data=%h exp 2 24 2", dbg_state, mem_addr, mem_wdata); end
    cpu_req = 1'b0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    tick();
    drive_idle();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_rst_mid_refill();
    test_read_miss_zero_wait();
    test_read_miss_wait();
    test_write();
    test_read_hit();
    test_spurious_and_drop();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
